// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencing controller.
package muldiv_ctrl_pkg;

  // M-extension op codes: bit3 = 32-bit (w) form, bit2 = divide family,
  // bit1 = remainder, bit0 = unsigned.
  typedef enum logic [3:0] {
    MUL_OP_MUL   = 4'b0000,
    MUL_OP_DIV   = 4'b0100,
    MUL_OP_DIVU  = 4'b0101,
    MUL_OP_REM   = 4'b0110,
    MUL_OP_REMU  = 4'b0111,
    MUL_OP_MULW  = 4'b1000,
    MUL_OP_DIVW  = 4'b1100,
    MUL_OP_DIVUW = 4'b1101,
    MUL_OP_REMW  = 4'b1110,
    MUL_OP_REMUW = 4'b1111
  } mulOp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } ctrlState_e;

  localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  // True for the ten op codes the datapath understands.
  function automatic logic isLegalOp(input logic [3:0] op);
    case (op)
      MUL_OP_MUL, MUL_OP_DIV, MUL_OP_DIVU, MUL_OP_REM, MUL_OP_REMU,
      MUL_OP_MULW, MUL_OP_DIVW, MUL_OP_DIVUW, MUL_OP_REMW, MUL_OP_REMUW:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_special.sv
// Combinational classifier for ops that never need the iterative datapath:
// illegal op codes, divide-by-zero and signed-overflow divides.
module muldiv_special
  import muldiv_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic        isSpecial_o,
  output logic        isIllegal_o,
  output logic [63:0] result_o
);

  logic isW;
  logic isDivFam;
  logic isRem;
  logic isUns;
  logic divZero;
  logic overflow;

  assign isW      = op_i[3];
  assign isDivFam = op_i[2];
  assign isRem    = op_i[1];
  assign isUns    = op_i[0];

  // Word ops only look at the low halves of the operands.
  assign divZero  = isW ? (b_i[31:0] == 32'd0) : (b_i == 64'd0);
  assign overflow = !isUns &&
                    (isW ? ((a_i[31:0] == INT32_MIN) && (b_i[31:0] == 32'hFFFF_FFFF))
                         : ((a_i == INT64_MIN) && (b_i == 64'hFFFF_FFFF_FFFF_FFFF)));

  // Resolve the RISC-V defined results for the corner cases locally.
  always_comb begin
    isIllegal_o = !isLegalOp(op_i);
    isSpecial_o = 1'b0;
    result_o    = 64'd0;
    if (!isIllegal_o && isDivFam) begin
      if (divZero) begin
        isSpecial_o = 1'b1;
        if (!isRem)   result_o = 64'hFFFF_FFFF_FFFF_FFFF;
        else if (isW) result_o = {{32{a_i[31]}}, a_i[31:0]};
        else          result_o = a_i;
      end else if (overflow) begin
        isSpecial_o = 1'b1;
        if (isRem)    result_o = 64'd0;
        else if (isW) result_o = {32'hFFFF_FFFF, INT32_MIN};
        else          result_o = a_i;
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencing controller between execute and the iterative mul/div datapath.
// One op in flight; corner cases answered locally; flush drains safely.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_err,
  input  logic        flush,
  output logic        dp_en,
  output logic        dp_newOp,
  output logic [3:0]  dp_op,
  output logic [63:0] dp_a,
  output logic [63:0] dp_b,
  input  logic        dp_busy,
  input  logic [63:0] dp_out
);

  localparam int CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  ctrlState_e    state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [63:0]   a_q, a_d;
  logic [63:0]   b_q, b_d;
  logic [63:0]   respData_q, respData_d;
  logic          respErr_q, respErr_d;
  logic [CntW-1:0] wdCnt_q, wdCnt_d;

  logic          isSpecial;
  logic          isIllegal;
  logic [63:0]   specResult;

  muldiv_special u_special (
    .op_i        (req_op),
    .a_i         (req_a),
    .b_i         (req_b),
    .isSpecial_o (isSpecial),
    .isIllegal_o (isIllegal),
    .result_o    (specResult)
  );

  // State, operand latches, response holding registers and watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= 4'd0;
      a_q        <= 64'd0;
      b_q        <= 64'd0;
      respData_q <= 64'd0;
      respErr_q  <= 1'b0;
      wdCnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      respData_q <= respData_d;
      respErr_q  <= respErr_d;
      wdCnt_q    <= wdCnt_d;
    end
  end

  // Next-state and handshake outputs; flush is tested before completion.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    respData_d = respData_q;
    respErr_d  = respErr_q;
    wdCnt_d    = wdCnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dp_en      = 1'b0;
    dp_newOp   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d       = req_op;
          a_d        = req_a;
          b_d        = req_b;
          respData_d = 64'd0;
          respErr_d  = 1'b0;
          if (isIllegal) begin
            respErr_d = 1'b1;
            state_d   = ST_DONE;
          end else if (isSpecial) begin
            respData_d = specResult;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        dp_en    = 1'b1;
        dp_newOp = 1'b1;
        wdCnt_d  = '0;
        state_d  = flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        dp_en = 1'b1;
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (!dp_busy) begin
          respData_d = dp_out;
          respErr_d  = 1'b0;
          state_d    = ST_DONE;
        end else if (wdCnt_q == CntW'(TIMEOUT - 1)) begin
          respData_d = 64'd0;
          respErr_d  = 1'b1;
          state_d    = ST_DONE;
        end else begin
          wdCnt_d = wdCnt_q + CntW'(1);
        end
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        if (flush || resp_ready) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        dp_en = 1'b1;
        if (!dp_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_data = respData_q;
  assign resp_err  = respErr_q && resp_valid;
  assign dp_op     = op_q;
  assign dp_a      = a_q;
  assign dp_b      = b_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table, corner sequences and
// randomized ops against an arithmetic reference of RISC-V M semantics.
module tb_muldiv_ctrl;

  localparam int TIMEOUT = 127;
  localparam int MAXC    = 400;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [63:0] req_a, req_b;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        flush;
  logic        dp_en, dp_newOp;
  logic [3:0]  dp_op;
  logic [63:0] dp_a, dp_b;
  logic        dpBusy = 1'b0;
  logic [63:0] dpOut  = 64'd0;

  int errors = 0;
  int checks = 0;

  muldiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .flush(flush),
    .dp_en(dp_en), .dp_newOp(dp_newOp), .dp_op(dp_op),
    .dp_a(dp_a), .dp_b(dp_b), .dp_busy(dpBusy), .dp_out(dpOut)
  );

  always #5 clk = ~clk;

  // Reference RISC-V M result computed directly with language arithmetic.
  function automatic logic [63:0] refResult(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    longint      sa, sb;
    int          sa32, sb32;
    logic [31:0] ua32, ub32, r32;
    logic [63:0] minus1;
    minus1 = '1;
    sa = a; sb = b;
    ua32 = a[31:0]; ub32 = b[31:0];
    sa32 = ua32; sb32 = ub32;
    r32 = 32'd0;
    case (op)
      4'b0000: return a * b;
      4'b0100: begin
        if (b == 0) return minus1;
        if (a == 64'h8000_0000_0000_0000 && b == minus1) return a;
        return sa / sb;
      end
      4'b0101: return (b == 0) ? minus1 : a / b;
      4'b0110: begin
        if (b == 0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == minus1) return 64'd0;
        return sa % sb;
      end
      4'b0111: return (b == 0) ? a : a % b;
      4'b1000: r32 = ua32 * ub32;
      4'b1100: begin
        if (ub32 == 0) return minus1;
        if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = ua32;
        else r32 = sa32 / sb32;
      end
      4'b1101: begin
        if (ub32 == 0) return minus1;
        r32 = ua32 / ub32;
      end
      4'b1110: begin
        if (ub32 == 0) r32 = ua32;
        else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = 32'd0;
        else r32 = sa32 % sb32;
      end
      4'b1111: r32 = (ub32 == 0) ? ua32 : ua32 % ub32;
      default: return 64'd0;
    endcase
    return {{32{r32[31]}}, r32};
  endfunction

  function automatic bit refLegal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                      4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
  endfunction

  // Ops answered without the datapath: divides by zero or signed overflow.
  function automatic bit refLocal(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    bit w;
    w = op[3];
    if (!refLegal(op) || !(op inside {4'b0100, 4'b0101, 4'b0110, 4'b0111,
                                      4'b1100, 4'b1101, 4'b1110, 4'b1111})) return 0;
    if (w ? (b[31:0] == 0) : (b == 0)) return 1;
    if (op == 4'b0100 || op == 4'b0110)
      return (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    if (op == 4'b1100 || op == 4'b1110)
      return (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    return 0;
  endfunction

  // Model datapath: busy for busyLen cycles after the start pulse.
  int          busyLen = 5;
  int          busyLeft = 0;
  bit          stuckBusy = 0;
  logic [63:0] pending = 64'd0;

  always @(posedge clk) begin
    if (dp_newOp) begin
      dpBusy   <= 1'b1;
      busyLeft <= busyLen - 1;
      pending  <= refResult(dp_op, dp_a, dp_b);
      dpOut    <= 64'hBAD0_BAD0_BAD0_BAD0;
    end else if (dpBusy && !stuckBusy) begin
      if (busyLeft == 0) begin
        dpBusy <= 1'b0;
        dpOut  <= pending;
      end else begin
        busyLeft <= busyLeft - 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".req_ready"},  64'(req_ready),  64'd1);
    checkOutput({tag, ".resp_valid"}, 64'(resp_valid), 64'd0);
    checkOutput({tag, ".resp_err"},   64'(resp_err),   64'd0);
    checkOutput({tag, ".resp_data"},  resp_data,       64'd0);
    checkOutput({tag, ".dp_en"},      64'(dp_en),      64'd0);
    checkOutput({tag, ".dp_newOp"},   64'(dp_newOp),   64'd0);
    checkOutput({tag, ".dp_op"},      64'(dp_op),      64'd0);
    checkOutput({tag, ".dp_a"},       dp_a,            64'd0);
    checkOutput({tag, ".dp_b"},       dp_b,            64'd0);
  endtask

  // Present one request at a negedge and observe until resp_valid.
  task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                               input int len, output logic [63:0] data, output logic err,
                               output int lat, output int pulses, output bit readyLeak,
                               output bit operandBad);
    bit done;
    busyLen = len;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0; req_op = ~op; req_a = ~a; req_b = ~b;
    lat = 0; pulses = 0; data = 64'd0; err = 1'b0;
    readyLeak = 0; operandBad = 0; done = 0;
    for (int c = 1; c <= MAXC && !done; c++) begin
      if (dp_newOp) pulses++;
      if (dp_en && (dp_op !== op || dp_a !== a || dp_b !== b)) operandBad = 1;
      if (resp_valid) begin
        lat = c; data = resp_data; err = resp_err; done = 1;
      end else begin
        if (req_ready) readyLeak = 1;
        @(negedge clk);
      end
    end
  endtask

  // Hold resp_ready low for hold cycles, then consume and expect IDLE.
  task automatic completeResp(input string name, input int hold);
    logic [63:0] snapData;
    logic        snapErr;
    bit          unstable;
    snapData = resp_data; snapErr = resp_err; unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!resp_valid || resp_data !== snapData || resp_err !== snapErr) unstable = 1;
    end
    if (hold > 0) checkOutput({name, ".held_unstable"}, 64'(unstable), 64'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput({name, ".idle_resp_valid"}, 64'(resp_valid), 64'd0);
    checkOutput({name, ".idle_req_ready"},  64'(req_ready),  64'd1);
  endtask

  task automatic runAndCheck(input string name, input logic [3:0] op, input logic [63:0] a,
                             input logic [63:0] b, input int len, input logic [63:0] expData,
                             input logic expErr, input int expLat, input int hold);
    logic [63:0] data;
    logic        err;
    int          lat, pulses;
    bit          readyLeak, operandBad;
    applyStimulus(op, a, b, len, data, err, lat, pulses, readyLeak, operandBad);
    checkOutput({name, ".latency"},   64'(lat),        64'(expLat));
    checkOutput({name, ".data"},      data,            expData);
    checkOutput({name, ".err"},       64'(err),        64'(expErr));
    checkOutput({name, ".pulses"},    64'(pulses),     64'(expLat > 1 ? 1 : 0));
    checkOutput({name, ".req_ready"}, 64'(readyLeak),  64'd0);
    checkOutput({name, ".operands"},  64'(operandBad), 64'd0);
    if (lat != 0) completeResp(name, hold);
  endtask

  task automatic waitDpIdle(input string name);
    int n;
    n = 0;
    while (dpBusy && n < MAXC) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, ".dp_drain"}, 64'(dpBusy), 64'd0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    int          len;
    logic [63:0] expData;
    logic        expErr;
    int          expLat;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #3_000_000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    logic [3:0]  op;
    logic [63:0] a, b, expData;
    logic [3:0]  opList[12];
    int          sel, len, expLat, cnt;
    bit          sawResp, notDrain;

    vecs[0]  = '{4'b0000, 64'd3, 64'd5, 17, 64'd15, 1'b0, 20};
    vecs[1]  = '{4'b0101, 64'd7, 64'd0, 5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1};
    vecs[2]  = '{4'b1110, 64'h8000_0000, 64'hFFFF_FFFF, 5, 64'd0, 1'b0, 1};
    vecs[3]  = '{4'b1100, 64'h8000_0000, 64'hFFFF_FFFF, 5, 64'hFFFF_FFFF_8000_0000, 1'b0, 1};
    vecs[4]  = '{4'b0010, 64'd1, 64'd2, 5, 64'd0, 1'b1, 1};
    vecs[5]  = '{4'b0110, 64'h1234, 64'd0, 5, 64'h1234, 1'b0, 1};
    vecs[6]  = '{4'b1111, 64'hFFFF_FFFF_8765_4321, 64'h1_0000_0000, 5, 64'hFFFF_FFFF_8765_4321, 1'b0, 1};
    vecs[7]  = '{4'b0100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5, 64'h8000_0000_0000_0000, 1'b0, 1};
    vecs[8]  = '{4'b0110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5, 64'd0, 1'b0, 1};
    vecs[9]  = '{4'b1000, 64'd0, 64'd7, 4, 64'd0, 1'b0, 7};
    vecs[10] = '{4'b0101, 64'd100, 64'd7, 5, 64'd14, 1'b0, 8};
    vecs[11] = '{4'b1100, 64'h8000_0000, 64'hFFFF_FFFE, 3, 64'h4000_0000, 1'b0, 6};
    vecs[12] = '{4'b1101, 64'd5, 64'h7_0000_0000, 5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1};
    vecs[13] = '{4'b1110, 64'd9, 64'h5_0000_0000, 5, 64'd9, 1'b0, 1};
    vecs[14] = '{4'b1011, 64'd3, 64'd3, 5, 64'd0, 1'b1, 1};

    opList = '{4'b0000, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000,
               4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0011, 4'b1001};

    reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = 64'd0; req_b = 64'd0;
    resp_ready = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;
    @(negedge clk);

    // Table of directed vectors, run back to back.
    for (int i = 0; i < 15; i++)
      runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].len,
                  vecs[i].expData, vecs[i].expErr, vecs[i].expLat, (i == 1) ? 5 : (i % 3));

    // Flush two cycles into WAIT: drains until the datapath goes idle.
    busyLen = 12;
    req_valid = 1'b1; req_op = 4'b0100; req_a = 64'd100; req_b = 64'd7;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    cnt = 0; sawResp = 0; notDrain = 0;
    while (!req_ready && cnt < MAXC) begin
      if (resp_valid) sawResp = 1;
      if (!dp_en) notDrain = 1;
      @(negedge clk);
      cnt++;
    end
    checkOutput("flushWait.cycles", 64'(cnt), 64'd11);
    checkOutput("flushWait.resp_valid", 64'(sawResp), 64'd0);
    checkOutput("flushWait.dp_en", 64'(notDrain), 64'd0);
    checkOutput("flushWait.dp_busy", 64'(dpBusy), 64'd0);

    // Flush while holding a result drops it.
    req_valid = 1'b1; req_op = 4'b0101; req_a = 64'd1; req_b = 64'd0;
    @(negedge clk); req_valid = 1'b0;
    checkOutput("flushDone.valid", 64'(resp_valid), 64'd1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checkOutput("flushDone.resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("flushDone.req_ready", 64'(req_ready), 64'd1);

    // Flush in IDLE does not block acceptance.
    flush = 1'b1;
    req_valid = 1'b1; req_op = 4'b0111; req_a = 64'd42; req_b = 64'd0;
    @(negedge clk); req_valid = 1'b0; flush = 1'b0;
    checkOutput("flushIdle.resp_valid", 64'(resp_valid), 64'd1);
    checkOutput("flushIdle.data", resp_data, 64'd42);
    completeResp("flushIdle", 0);

    // Stuck datapath: watchdog answers with an error.
    stuckBusy = 1;
    runAndCheck("timeout", 4'b0100, 64'd100, 64'd7, 5, 64'd0, 1'b1, TIMEOUT + 2, 1);
    stuckBusy = 0;
    waitDpIdle("timeout");

    // Reset in the middle of WAIT.
    busyLen = 30;
    req_valid = 1'b1; req_op = 4'b0000; req_a = 64'd9; req_b = 64'd9;
    @(negedge clk); req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("resetWait.dp_en", 64'(dp_en), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkResetValues("resetWait");
    reset = 1'b0;
    waitDpIdle("resetWait");

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 11);
      op  = opList[sel];
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = op[3] ? {$urandom, 32'd0} : 64'd0;
        1: begin
          if (op[3]) begin
            a = {$urandom, 32'h8000_0000}; b = {$urandom, 32'hFFFF_FFFF};
          end else begin
            a = 64'h8000_0000_0000_0000; b = 64'hFFFF_FFFF_FFFF_FFFF;
          end
        end
        2: b = 64'($urandom_range(1, 9));
        default: ;
      endcase
      len = $urandom_range(1, 20);
      if (!refLegal(op)) begin
        expData = 64'd0; expLat = 1;
      end else begin
        expData = refResult(op, a, b);
        expLat  = refLocal(op, a, b) ? 1 : len + 3;
      end
      runAndCheck($sformatf("rnd%0d", i), op, a, b, len, expData, !refLegal(op),
                  expLat, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller between the execute stage and the iterative multiply/divide datapath. Accepts one M-extension operation at a time over a valid/ready handshake and launches it on the datapath with a one-cycle start pulse. It waits out the datapath's busy period, then holds the result until the pipeline takes it. RISC-V divide-by-zero and signed-overflow cases are resolved locally without touching the datapath, and a pipeline flush mid-operation is absorbed safely.

## Interface
Parameters:
- TIMEOUT, 127: max cycles in WAIT before the watchdog fires

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  execute stage presents an operation
- req_ready  out  1  controller can accept; high only in IDLE
- req_op  in  4  op code: 0000 mul, 0100 div, 0101 divu, 0110 rem, 0111 remu, 1000 mulw, 1100 divw, 1101 divuw, 1110 remw, 1111 remuw
- req_a, req_b  in  64  operands (u64)
- resp_valid  out  1  result available
- resp_ready  in  1  pipeline consumes result
- resp_data  out  64  result
- resp_err  out  1  with resp_valid: illegal op or watchdog timeout
- flush  in  1  discard the in-flight operation
- dp_en  out  1  datapath enable
- dp_newOp  out  1  one-cycle start pulse
- dp_op  out  4  op to datapath
- dp_a, dp_b  out  64  latched operands
- dp_busy  in  1  datapath busy; registered, high from the cycle after dp_newOp
- dp_out  in  64  datapath result, valid once dp_busy falls

## Operation
States:
- IDLE: req_ready=1. On req_valid, latch op/a/b and classify. Illegal op: resp_data=0, resp_err=1, go to DONE. Special case: compute the result locally, go to DONE. Otherwise go to ISSUE.
- ISSUE: dp_newOp=1 for exactly one cycle; go to WAIT.
- WAIT: clear the watchdog count on entry, increment each cycle. When dp_busy==0, capture dp_out into resp_data and go to DONE. If the count reaches TIMEOUT, set resp_data=0, resp_err=1, go to DONE.
- DONE: resp_valid=1, and resp_data/resp_err hold stable. On resp_ready, go to IDLE.
- DRAIN: entered on flush from ISSUE or WAIT. No response is produced; stay until dp_busy==0, then go to IDLE.
- Flush in IDLE has no effect. Flush in DONE drops the result and goes to IDLE.
- Flush has priority over completion in the same cycle.

Datapath drive:
- dp_en=1 in ISSUE, WAIT and DRAIN; 0 otherwise.
- dp_op/dp_a/dp_b are driven from the latched registers and stay stable for the whole operation.

Special cases, all 64-bit results:
- Divisor zero. Operand is b[63:0], or b[31:0] for w-ops.
  - div/divu/divw/divuw: all ones.
  - rem/remu: a.
  - remw/remuw: sext(a[31:0]).
- Signed overflow:
  - div: a=0x8000_0000_0000_0000, b=-1 gives a; rem gives 0.
  - divw: a[31:0]=0x8000_0000, b[31:0]=0xFFFF_FFFF gives 0xFFFF_FFFF_8000_0000; remw gives 0.
- Any other op, including mul and mulw with zero operands, goes to the datapath.

## Timing
- Reset: state=IDLE; all outputs 0 except req_ready=1; latched registers cleared. Reset in any state, DRAIN included, returns to IDLE next cycle. The datapath is not reset by this block.
- A request is accepted on the posedge with req_valid && req_ready.
- Special case or illegal op: resp_valid rises the cycle after acceptance (latency 1).
- Datapath op: ISSUE in cycle +1, WAIT from +2. resp_valid appears one cycle after the first WAIT cycle sampling dp_busy==0.
- Back-to-back: resp_ready in DONE lets req_ready rise the next cycle. There is no acceptance in the same cycle as resp handshake.
- resp_valid is never withdrawn without resp_ready, except by flush or reset.

## Structure
- The common package holds:
  - the op-code enum (MUL_OP_MUL … MUL_OP_REMUW)
  - the state enum
  - helper constants INT64_MIN and INT32_MIN
- The special-case classifier and result (combinational: op, a, b → is_special, is_illegal, result) is a sub-module, muldiv_special, so it can be unit-tested alone.
- The FSM, watchdog counter and latches stay in muldiv_ctrl.

## Test plan
- mul a=3, b=5 with a model datapath (busy 17 cycles) → one dp_newOp pulse; resp_valid with resp_data=15, resp_err=0; req_ready low throughout.
- divu a=7, b=0 → no dp_newOp; resp_valid the cycle after accept; data=0xFFFF_FFFF_FFFF_FFFF.
- remw a=0x8000_0000, b=0xFFFF_FFFF → data=0, latency 1. Same with divw → data=0xFFFF_FFFF_8000_0000.
- flush two cycles into WAIT; model busy for 10 more cycles → no resp_valid; req_ready stays 0 until dp_busy falls, then 1.
- resp_ready held low 5 cycles in DONE → resp_data stable; on resp_ready=1, IDLE next cycle; immediate next request accepted.
- op 0010 → resp_err=1, data=0. Separately, dp_busy stuck high → resp_err=1 after TIMEOUT cycles in WAIT. Reset asserted mid-WAIT → IDLE next cycle, all outputs at reset values.
